gat_bram_load_ctrl: RTL and testbench
=====================================

# gat_bram_load_ctrl

Multi-channel host-to-core BRAM bridge and layer sequencer for the GAT accelerator, sitting between the AXI BRAM controllers and the `gat_top` core. It converts 32-bit byte-addressed host write ports into word-addressed, width-truncated core write ports over NUM_CH channels. It tracks per-channel load completion from word counts or software override, and sequences the layer through start, run and ready. It also serves the new-feature read-back port with a fixed, flagged latency.

## Interface
- NUM_CH, 3: number of host write channels (H data, node info, weight).
- ADDR_W, 20: host byte-address width per channel; core address width is ADDR_W-2.
- OUT_W, 20: core data width; the host word is truncated to bits [OUT_W-1:0].
- CNT_W, 18: width of the per-channel word counter and of load_len fields.
- RD_LAT, 2: core feature-BRAM read latency in cycles (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- gat_layer  in  1  level; each rising edge starts a layer.
- gat_ready  out  1  layer result valid.
- load_len  in  NUM_CH*CNT_W  expected word count per channel; 0 means the channel is disabled (always done).
- ch_load_done  in  NUM_CH  software done override per channel, sampled as a level.
- bram_din  in  NUM_CH*32  host write data.
- bram_ena, bram_wea  in  NUM_CH each  host enable and write enable.
- bram_addra  in  NUM_CH*ADDR_W  host byte address.
- core_din  out  NUM_CH*OUT_W  registered write data.
- core_we  out  NUM_CH  registered write strobe.
- core_addr  out  NUM_CH*(ADDR_W-2)  registered word address.
- core_start  out  1  one-cycle layer start pulse.
- core_done  in  1  core layer-complete pulse.
- feat_bram_enb  in  1  host read enable.
- feat_bram_addrb  in  ADDR_W  host read byte address.
- feat_bram_dout  out  32  read data, zero-extended.
- feat_rd_valid  out  1  marks the cycle in which feat_bram_dout is valid.
- core_rd_en  out  1  combinational from feat_bram_enb.
- core_rd_addr  out  ADDR_W-2  combinational, equal to feat_bram_addrb[ADDR_W-1:2].
- core_rd_data  in  OUT_W  core read data.
- err_misalign  out  NUM_CH  sticky per-channel error flag.
- err_late  out  NUM_CH  sticky per-channel error flag.
- state  out  3  FSM state encoding: IDLE=0, LOAD=1, START=2, RUN=3, DONE=4.

## Operation
- Write accept condition for channel c: ena&wea, addra[1:0]==0, and state is IDLE or LOAD.
  - On accept, the registered core_we/core_addr/core_din is issued one cycle later.
  - On accept, cnt[c] increments, saturating at all-ones.
- Misaligned write (addra[1:0]!=0): dropped; err_misalign[c] is set.
- Write in START, RUN or DONE: dropped; err_late[c] is set.
- Error flags clear only on reset.
- Channel done: ch_done[c] = (load_len[c]==0) | (cnt[c]>=load_len[c]) | ch_load_done[c]. all_done is the AND over all channels.
- FSM:
  - IDLE → LOAD on a gat_layer rising edge (edge detected via a registered copy of gat_layer).
  - LOAD → START when all_done.
  - START: core_start=1 for exactly one cycle, then → RUN.
  - RUN → DONE on core_done.
  - DONE: gat_ready=1. On a gat_layer rising edge, clear all cnt and → LOAD.
- Counters are not cleared on IDLE→LOAD, so the host may preload before the first edge.
- A gat_layer edge in LOAD, START or RUN is ignored.
- A core_done outside RUN is ignored.
- Read path: core_rd_* are combinational passthroughs. After RD_LAT cycles, core_rd_data is registered into feat_bram_dout with zero-extension above bit OUT_W-1. feat_bram_dout holds its value between reads.

## Timing
- Reset values: core_we=0, core_din=0, core_addr=0, core_start=0, gat_ready=0, feat_bram_dout=0, feat_rd_valid=0, all error flags 0, all cnt 0, state=IDLE. Reset mid-layer returns to IDLE from any state within the same edge.
- Write latency: host write in cycle t → core_we high in cycle t+1.
- Read latency: enb in cycle t → feat_rd_valid and feat_bram_dout valid in cycle t+RD_LAT+1. Back-to-back reads sustain one per cycle through an RD_LAT+1-deep valid shift register.
- Done-to-start: all_done observed in cycle t (in LOAD) → START in t+1 → core_start high in t+1 → RUN in t+2.
- The final accepted write that completes a channel counts in the same edge as the LOAD→START evaluation of the following cycle; no write is lost.
- Simultaneous DONE edge and host write in the same cycle: the write is dropped (err_late set) and counters clear.
- gat_ready falls in the cycle after the DONE→LOAD edge.

## Test plan
- Preload H data: load_len={4,2,3}, write 4/2/3 aligned words at byte addresses 0x0,0x4,... in IDLE, then raise gat_layer → state 1→2; core_start pulses once; core_addr sequence is 0,1,2,3 and core_din equals din[19:0].
- Misaligned write: write to address 0x6 on ch1 → no core_we; err_misalign=3'b010; cnt unchanged; LOAD holds.
- Override and disable: load_len[0]=0, ch_load_done[2]=1, ch1 receives its 5 words → START reached with no writes on ch0 or ch2.
- Late write: write during RUN → dropped, err_late[c]=1. Then core_done → gat_ready=1. A second gat_layer edge clears counters, LOAD is re-entered, and gat_ready=0 the next cycle.
- Read-back: with RD_LAT=2, feature reads at addresses 0x0,0x4,0x8 in consecutive cycles, core_rd_data=0xABCDE,0x00001,0xFFFFF → feat_bram_dout = 0x000ABCDE,0x00000001,0x000FFFFF in cycles t+3..t+5, with feat_rd_valid high for those 3 cycles.
- Reset mid-RUN: assert rst_n=0 during RUN → all outputs at their reset values and state=0; on release, no spurious core_start.

Source files
------------

// File: rtl/gat_bram_load_ctrl.sv
// Host-to-core BRAM bridge and layer sequencer for the GAT accelerator.
// Byte-addressed 32-bit host writes become word-addressed, truncated core writes; one FSM gates the layer.
module gat_bram_load_ctrl #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 20,
    parameter int OUT_W  = 20,
    parameter int CNT_W  = 18,
    parameter int RD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       gat_layer,
    output logic                       gat_ready,
    input  logic [NUM_CH*CNT_W-1:0]    load_len,
    input  logic [NUM_CH-1:0]          ch_load_done,
    input  logic [NUM_CH*32-1:0]       bram_din,
    input  logic [NUM_CH-1:0]          bram_ena,
    input  logic [NUM_CH-1:0]          bram_wea,
    input  logic [NUM_CH*ADDR_W-1:0]   bram_addra,
    output logic [NUM_CH*OUT_W-1:0]    core_din,
    output logic [NUM_CH-1:0]          core_we,
    output logic [NUM_CH*(ADDR_W-2)-1:0] core_addr,
    output logic                       core_start,
    input  logic                       core_done,
    input  logic                       feat_bram_enb,
    input  logic [ADDR_W-1:0]          feat_bram_addrb,
    output logic [31:0]                feat_bram_dout,
    output logic                       feat_rd_valid,
    output logic                       core_rd_en,
    output logic [ADDR_W-3:0]          core_rd_addr,
    input  logic [OUT_W-1:0]           core_rd_data,
    output logic [NUM_CH-1:0]          err_misalign,
    output logic [NUM_CH-1:0]          err_late,
    output logic [2:0]                 state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_layer_d;
    logic               r_core_start;
    logic               r_gat_ready;
    logic               w_layer_rise;
    logic               w_wr_open;
    logic               w_cnt_clr;
    logic               w_all_done;
    logic [NUM_CH-1:0]  w_ch_done;
    logic               w_unused_rd;

    assign w_layer_rise = gat_layer & ~r_layer_d;
    assign w_wr_open    = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_cnt_clr    = (r_state == S_DONE) && w_layer_rise;
    assign w_all_done   = &w_ch_done;

    assign state      = r_state;
    assign core_start = r_core_start;
    assign gat_ready  = r_gat_ready;

    // Per-channel write path, word counter and sticky error flags.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0]  r_cnt;
            logic              r_we;
            logic [OUT_W-1:0]  r_din;
            logic [ADDR_W-3:0] r_addr;
            logic              r_err_mis;
            logic              r_err_late;
            logic [CNT_W-1:0]  w_len;
            logic              w_req;
            logic              w_aligned;
            logic              w_accept;
            logic              w_unused_din;

            assign w_len        = load_len[gi*CNT_W +: CNT_W];
            assign w_req        = bram_ena[gi] & bram_wea[gi];
            assign w_aligned    = (bram_addra[gi*ADDR_W +: 2] == 2'b00);
            assign w_accept     = w_req & w_aligned & w_wr_open;
            assign w_unused_din = ^bram_din[gi*32+OUT_W +: 32-OUT_W];

            assign w_ch_done[gi] = (w_len == '0) || (r_cnt >= w_len) || ch_load_done[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt      <= '0;
                    r_we       <= 1'b0;
                    r_din      <= '0;
                    r_addr     <= '0;
                    r_err_mis  <= 1'b0;
                    r_err_late <= 1'b0;
                end else begin
                    r_we <= w_accept;
                    if (w_accept) begin
                        r_din  <= bram_din[gi*32 +: OUT_W];
                        r_addr <= bram_addra[gi*ADDR_W+2 +: ADDR_W-2];
                    end
                    // Clear wins: an accept can never coincide with the DONE-state clear.
                    if (w_cnt_clr)
                        r_cnt <= '0;
                    else if (w_accept && (r_cnt != {CNT_W{1'b1}}))
                        r_cnt <= r_cnt + 1'b1;
                    if (w_req && !w_aligned)
                        r_err_mis <= 1'b1;
                    if (w_req && !w_wr_open)
                        r_err_late <= 1'b1;
                end
            end

            assign core_we[gi]                           = r_we;
            assign core_din[gi*OUT_W +: OUT_W]           = r_din;
            assign core_addr[gi*(ADDR_W-2) +: ADDR_W-2]  = r_addr;
            assign err_misalign[gi]                      = r_err_mis;
            assign err_late[gi]                          = r_err_late;
        end
    endgenerate

    // Layer sequencer with registered start pulse and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_layer_d    <= 1'b0;
            r_core_start <= 1'b0;
            r_gat_ready  <= 1'b0;
        end else begin
            r_layer_d    <= gat_layer;
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_layer_rise)
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (w_all_done) begin
                        r_state      <= S_START;
                        r_core_start <= 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (core_done) begin
                        r_state     <= S_DONE;
                        r_gat_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_layer_rise) begin
                        r_state     <= S_LOAD;
                        r_gat_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_gat_ready <= 1'b0;
                end
            endcase
        end
    end

    // Feature read-back: valid shift register tracks in-flight reads; data captured when the core responds.
    logic [RD_LAT:0] r_rd_vld;
    logic [31:0]     r_feat_dout;

    assign core_rd_en     = feat_bram_enb;
    assign core_rd_addr   = feat_bram_addrb[ADDR_W-1:2];
    assign feat_rd_valid  = r_rd_vld[RD_LAT];
    assign feat_bram_dout = r_feat_dout;
    assign w_unused_rd    = ^feat_bram_addrb[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld    <= '0;
            r_feat_dout <= '0;
        end else begin
            r_rd_vld <= {r_rd_vld[RD_LAT-1:0], feat_bram_enb};
            if (r_rd_vld[RD_LAT-1])
                r_feat_dout <= 32'(core_rd_data);
        end
    end

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// Scoreboard bench for gat_bram_load_ctrl: directed writes/reads push expectations,
// a forked monitor pops and compares whenever core_we or feat_rd_valid is presented.
module tb_gat_bram_load_ctrl;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 20;
    localparam int OUT_W  = 20;
    localparam int CNT_W  = 18;
    localparam int RD_LAT = 2;

    typedef struct packed {
        logic [1:0]  ch;
        logic [17:0] addr;
        logic [19:0] din;
    } wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } rd_t;

    logic                         clk;
    logic                         rst_n;
    logic                         gat_layer;
    logic                         gat_ready;
    logic [NUM_CH*CNT_W-1:0]      load_len;
    logic [NUM_CH-1:0]            ch_load_done;
    logic [NUM_CH*32-1:0]         bram_din;
    logic [NUM_CH-1:0]            bram_ena;
    logic [NUM_CH-1:0]            bram_wea;
    logic [NUM_CH*ADDR_W-1:0]     bram_addra;
    logic [NUM_CH*OUT_W-1:0]      core_din;
    logic [NUM_CH-1:0]            core_we;
    logic [NUM_CH*(ADDR_W-2)-1:0] core_addr;
    logic                         core_start;
    logic                         core_done;
    logic                         feat_bram_enb;
    logic [ADDR_W-1:0]            feat_bram_addrb;
    logic [31:0]                  feat_bram_dout;
    logic                         feat_rd_valid;
    logic                         core_rd_en;
    logic [ADDR_W-3:0]            core_rd_addr;
    logic [OUT_W-1:0]             core_rd_data;
    logic [NUM_CH-1:0]            err_misalign;
    logic [NUM_CH-1:0]            err_late;
    logic [2:0]                   state;

    gat_bram_load_ctrl #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gat_layer(gat_layer), .gat_ready(gat_ready),
        .load_len(load_len), .ch_load_done(ch_load_done), .bram_din(bram_din),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
        .core_din(core_din), .core_we(core_we), .core_addr(core_addr),
        .core_start(core_start), .core_done(core_done),
        .feat_bram_enb(feat_bram_enb), .feat_bram_addrb(feat_bram_addrb),
        .feat_bram_dout(feat_bram_dout), .feat_rd_valid(feat_rd_valid),
        .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
        .err_misalign(err_misalign), .err_late(err_late), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core feature BRAM model: data appears RD_LAT cycles after the read enable.
    logic [OUT_W-1:0] mem [4];
    logic [OUT_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (core_rd_en) rd_pipe[0] <= mem[core_rd_addr[1:0]];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign core_rd_data = rd_pipe[RD_LAT-1];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  start_cnt = 0;
    wr_t exp_wr_q [$];
    rd_t exp_rd_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("[TB] ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic monitor();
        wr_t w;
        rd_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (core_start) start_cnt++;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (core_we[c]) begin
                        if (exp_wr_q.size() == 0) begin
                            check($sformatf("unexpected_wr_ch%0d", c), 32'd1, 32'd0);
                        end else begin
                            w = exp_wr_q.pop_front();
                            check("wr_ch",   32'(c), 32'(w.ch));
                            check("wr_addr", 32'(core_addr[c*(ADDR_W-2) +: ADDR_W-2]), 32'(w.addr));
                            check("wr_din",  32'(core_din[c*OUT_W +: OUT_W]), 32'(w.din));
                        end
                    end
                end
                if (feat_rd_valid) begin
                    if (exp_rd_q.size() == 0) begin
                        check("unexpected_rd_valid", 32'd1, 32'd0);
                    end else begin
                        r = exp_rd_q.pop_front();
                        check("rd_data",  feat_bram_dout, r.data);
                        check("rd_cycle", 32'(cyc), r.cyc);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int ch, input logic [31:0] addr, input logic [31:0] data,
                              input bit acc, input logic [17:0] e_addr, input logic [19:0] e_din);
        wr_t w;
        bram_ena[ch] = 1'b1;
        bram_wea[ch] = 1'b1;
        bram_addra[ch*ADDR_W +: ADDR_W] = addr[ADDR_W-1:0];
        bram_din[ch*32 +: 32] = data;
        if (acc) begin
            w.ch = 2'(ch);
            w.addr = e_addr;
            w.din = e_din;
            exp_wr_q.push_back(w);
        end
        $display("[TB] write ch%0d addr 0x%0h data 0x%08h accept=%0d", ch, addr, data, acc);
        tick();
        bram_ena = '0;
        bram_wea = '0;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (state == tgt) break;
            tick();
        end
        check(name, 32'(state), 32'(tgt));
    endtask

    task automatic feat_read(input logic [ADDR_W-1:0] addr, input logic [31:0] e_data);
        rd_t r;
        feat_bram_enb = 1'b1;
        feat_bram_addrb = addr;
        r.data = e_data;
        r.cyc = 32'(cyc + RD_LAT + 1);
        exp_rd_q.push_back(r);
        #1;
        check("rd_passthru_en", 32'(core_rd_en), 32'd1);
        check("rd_passthru_addr", 32'(core_rd_addr), 32'(addr >> 2));
        $display("[TB] read addr 0x%0h expect 0x%08h at cycle %0d", addr, e_data, r.cyc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sc;
        mem[0] = 20'hABCDE;
        mem[1] = 20'h00001;
        mem[2] = 20'hFFFFF;
        mem[3] = 20'h00000;
        rd_pipe[0] = '0;
        rd_pipe[1] = '0;
        rst_n = 1'b0;
        gat_layer = 1'b0;
        load_len = '0;
        ch_load_done = '0;
        bram_din = '0;
        bram_ena = '0;
        bram_wea = '0;
        bram_addra = '0;
        core_done = 1'b0;
        feat_bram_enb = 1'b0;
        feat_bram_addrb = '0;

        fork
            monitor();
            begin
                #400000;
                $display("[TB] FAIL watchdog: simulation exceeded time limit");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_core_we", 32'(core_we), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_gat_ready", 32'(gat_ready), 32'd0);
        check("rst_feat_dout", feat_bram_dout, 32'd0);
        check("rst_feat_valid", 32'(feat_rd_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // Preload in IDLE: ch0=3 words, ch1=2 words, ch2=4 words
        load_len = {18'd4, 18'd2, 18'd3};
        host_write(0, 32'h0, 32'h1234_5678, 1, 18'd0, 20'h45678);
        host_write(0, 32'h4, 32'hFFFF_FFFF, 1, 18'd1, 20'hFFFFF);
        host_write(0, 32'h8, 32'h0000_0001, 1, 18'd2, 20'h00001);
        host_write(1, 32'h0, 32'hDEAD_BEEF, 1, 18'd0, 20'hDBEEF);
        host_write(1, 32'h4, 32'h0000_ABCD, 1, 18'd1, 20'h0ABCD);
        host_write(2, 32'h0, 32'h1111_1111, 1, 18'd0, 20'h11111);
        host_write(2, 32'h4, 32'h2222_2222, 1, 18'd1, 20'h22222);
        host_write(2, 32'h8, 32'h3333_3333, 1, 18'd2, 20'h33333);
        host_write(2, 32'hC, 32'hCAFE_F00D, 1, 18'd3, 20'hEF00D);
        check("preload_idle", 32'(state), 32'd0);
        gat_layer = 1'b1;
        tick();
        check("edge_to_load", 32'(state), 32'd1);
        tick();
        check("start_state", 32'(state), 32'd2);
        check("start_pulse", 32'(core_start), 32'd1);
        tick();
        check("run_state", 32'(state), 32'd3);
        check("start_pulse_end", 32'(core_start), 32'd0);
        check("start_count", 32'(start_cnt), 32'd1);

        // Late write in RUN is dropped
        host_write(1, 32'h10, 32'h5555_5555, 0, 18'd0, 20'd0);
        check("err_late", 32'(err_late), 32'b010);
        check("err_misalign_clean", 32'(err_misalign), 32'b000);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("done_state", 32'(state), 32'd4);
        check("gat_ready", 32'(gat_ready), 32'd1);
        gat_layer = 1'b0;
        tick();
        check("done_hold", 32'(state), 32'd4);
        gat_layer = 1'b1;
        tick();
        check("relayer_load", 32'(state), 32'd1);
        check("gat_ready_fall", 32'(gat_ready), 32'd0);
        tick();
        tick();
        check("cnt_cleared_load_holds", 32'(state), 32'd1);

        // Misaligned write: ch1 needs one word, others overridden
        load_len = {18'd4, 18'd1, 18'd3};
        ch_load_done = 3'b101;
        host_write(1, 32'h6, 32'h7777_7777, 0, 18'd0, 20'd0);
        check("err_misalign", 32'(err_misalign), 32'b010);
        tick();
        tick();
        check("misalign_load_holds", 32'(state), 32'd1);

        // Override and disable: ch0 disabled, ch2 forced done, ch1 takes 5 words
        load_len = {18'd4, 18'd5, 18'd0};
        ch_load_done = 3'b100;
        host_write(1, 32'h0,  32'hAAAA_0000, 1, 18'd0, 20'hA0000);
        host_write(1, 32'h4,  32'h0001_2345, 1, 18'd1, 20'h12345);
        host_write(1, 32'h8,  32'h00F0_0F00, 1, 18'd2, 20'h00F00);
        host_write(1, 32'hC,  32'h8000_0001, 1, 18'd3, 20'h00001);
        tick();
        check("four_of_five_load", 32'(state), 32'd1);
        host_write(1, 32'h10, 32'h000F_FFFE, 1, 18'd4, 20'hFFFFE);
        wait_state(3'd2, 4, "override_start");
        tick();
        check("override_run", 32'(state), 32'd3);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("override_done", 32'(state), 32'd4);

        // Read-back in consecutive cycles
        feat_read(20'h0, 32'h000ABCDE);
        feat_read(20'h4, 32'h00000001);
        feat_read(20'h8, 32'h000FFFFF);
        feat_bram_enb = 1'b0;
        repeat (6) tick();
        check("rd_all_seen", 32'(exp_rd_q.size()), 32'd0);
        check("rd_hold", feat_bram_dout, 32'h000FFFFF);
        check("rd_valid_low", 32'(feat_rd_valid), 32'd0);

        // Reset mid-RUN
        gat_layer = 1'b0;
        tick();
        ch_load_done = 3'b111;
        gat_layer = 1'b1;
        tick();
        wait_state(3'd3, 6, "reach_run");
        sc = start_cnt;
        gat_layer = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_core_we", 32'(core_we), 32'd0);
        check("midrst_core_addr", 32'(core_addr[31:0]), 32'd0);
        check("midrst_core_din", 32'(core_din[31:0]), 32'd0);
        check("midrst_core_start", 32'(core_start), 32'd0);
        check("midrst_gat_ready", 32'(gat_ready), 32'd0);
        check("midrst_err_mis", 32'(err_misalign), 32'd0);
        check("midrst_err_late", 32'(err_late), 32'd0);
        check("midrst_feat_dout", feat_bram_dout, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_idle", 32'(state), 32'd0);
        check("no_spurious_start", 32'(start_cnt), 32'(sc));
        check("wr_all_seen", 32'(exp_wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
